// File: rtl/xeng_win_sched.sv
// xeng_win_sched
// Schedules one window at a time out of an upstream window buffer into the
// X-engine. When enabled and a full window is waiting, it emits a sync slot and
// then reads WIN_LEN samples back-to-back. It acknowledges the buffer on the last
// read and then idles for GAP_CYCLES cycles. The sync, valid and mcnt outputs are
// delayed by RD_LATENCY so they line up with the data from the buffer.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   en_i         scheduler enable, sampled only in IDLE
//   buf_rdy_i    upstream holds a complete window
//   buf_mcnt_i   mcnt of the upstream window, latched in SYNC
//   buf_ack_o    one-cycle pulse on the last read of a window
//   rd_en_o      buffer read enable
//   rd_addr_o    buffer read address, 0 outside RUN
//   xeng_sync_o  sync pulse, one cycle ahead of the first valid sample
//   xeng_vld_o   window valid, WIN_LEN cycles per window
//   xeng_mcnt_o  mcnt of the window being issued
//   busy_o       scheduler is not in IDLE
//   win_count_o  completed windows, wraps at 2^32
module xeng_win_sched #(
  parameter int SERIAL_ACC_LEN_BITS = 7,
  parameter int N_ANTS              = 64,
  parameter int MCNT_WIDTH          = 48,
  parameter int RD_LATENCY          = 2,
  parameter int GAP_CYCLES          = N_ANTS/2+1,
  localparam int WIN_LEN            = N_ANTS * (2**SERIAL_ACC_LEN_BITS),
  localparam int ADDR_W             = $clog2(WIN_LEN)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  buf_rdy_i,
  input  logic [MCNT_WIDTH-1:0] buf_mcnt_i,
  output logic                  buf_ack_o,
  output logic                  rd_en_o,
  output logic [ADDR_W-1:0]     rd_addr_o,
  output logic                  xeng_sync_o,
  output logic                  xeng_vld_o,
  output logic [MCNT_WIDTH-1:0] xeng_mcnt_o,
  output logic                  busy_o,
  output logic [31:0]           win_count_o
);

  localparam int GAP_W = $clog2(GAP_CYCLES+1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIN_LEN-1);
  // buf_ack is registered, so it is raised one address ahead of the last one
  // (assumes WIN_LEN >= 2).
  localparam logic [ADDR_W-1:0] PRE_ADDR  = ADDR_W'(WIN_LEN-2);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES-1);

  typedef enum logic [1:0] {IDLE, SYNC, RUN, GAP} state_e;

  state_e                  state_q;
  logic                    rd_en_q;
  logic [ADDR_W-1:0]       rd_addr_q;
  logic                    buf_ack_q;
  logic                    busy_q;
  logic [GAP_W-1:0]        gap_cnt_q;
  logic [MCNT_WIDTH-1:0]   mcnt_q;

  // Scheduler FSM; every output it drives is a register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      buf_ack_q <= 1'b0;
      busy_q    <= 1'b0;
      gap_cnt_q <= '0;
      mcnt_q    <= '0;
    end else begin
      buf_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en_i && buf_rdy_i) begin
            state_q <= SYNC;
            busy_q  <= 1'b1;
          end
        end
        SYNC: begin
          mcnt_q    <= buf_mcnt_i;
          state_q   <= RUN;
          rd_en_q   <= 1'b1;
          rd_addr_q <= '0;
        end
        RUN: begin
          buf_ack_q <= (rd_addr_q == PRE_ADDR);
          if (rd_addr_q == LAST_ADDR) begin
            state_q   <= GAP;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            gap_cnt_q <= '0;
          end else begin
            rd_addr_q <= rd_addr_q + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Delay lines that match the buffer read latency. Tap 0 is the undelayed
  // signal, and tap RD_LATENCY is what leaves the block.
  logic                  sync_now;
  logic [RD_LATENCY-1:0] sync_dly_q, vld_dly_q;
  logic [RD_LATENCY:0]   sync_tap, vld_tap;
  logic [MCNT_WIDTH-1:0] xeng_mcnt_q;
  logic [31:0]           win_count_q;

  assign sync_now = (state_q == SYNC);
  assign sync_tap = {sync_dly_q, sync_now};
  assign vld_tap  = {vld_dly_q, rd_en_q};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_dly_q  <= '0;
      vld_dly_q   <= '0;
      xeng_mcnt_q <= '0;
      win_count_q <= '0;
    end else begin
      sync_dly_q <= sync_tap[RD_LATENCY-1:0];
      vld_dly_q  <= vld_tap[RD_LATENCY-1:0];
      // Load one stage before the sync leaves the block, so the mcnt changes
      // together with the sync. With a latency of 1 that stage is SYNC itself,
      // and mcnt_q is not loaded yet, so take the input directly.
      if (sync_tap[RD_LATENCY-1])
        xeng_mcnt_q <= sync_now ? buf_mcnt_i : mcnt_q;
      // Count on the last valid sample, which is the cycle before xeng_vld falls.
      if (vld_tap[RD_LATENCY] && !vld_tap[RD_LATENCY-1])
        win_count_q <= win_count_q + 32'd1;
    end
  end

  assign buf_ack_o   = buf_ack_q;
  assign rd_en_o     = rd_en_q;
  assign rd_addr_o   = rd_addr_q;
  assign busy_o      = busy_q;
  assign xeng_sync_o = sync_tap[RD_LATENCY];
  assign xeng_vld_o  = vld_tap[RD_LATENCY];
  assign xeng_mcnt_o = xeng_mcnt_q;
  assign win_count_o = win_count_q;

endmodule

// File: tb/tb_xeng_win_sched.sv
// Testbench for xeng_win_sched with N_ANTS=4, SERIAL_ACC_LEN_BITS=2 (WIN_LEN=16),
// RD_LATENCY=2 and GAP_CYCLES=3. The reference model holds only the start cycle
// of the current window. Each output is a simple function of the cycle offset
// from that start.
module tb_xeng_win_sched;
  localparam int SAB = 2;
  localparam int NA  = 4;
  localparam int MW  = 48;
  localparam int LAT = 2;
  localparam int GAP = 3;
  localparam int WIN = NA * (2**SAB);
  localparam int AW  = $clog2(WIN);

  logic          clk = 1'b0;
  logic          rst, en, buf_rdy;
  logic [MW-1:0] buf_mcnt;
  logic          buf_ack_o, rd_en_o, xeng_sync_o, xeng_vld_o, busy_o;
  logic [AW-1:0] rd_addr_o;
  logic [MW-1:0] xeng_mcnt_o;
  logic [31:0]   win_count_o;

  always #5 clk = ~clk;

  xeng_win_sched #(
    .SERIAL_ACC_LEN_BITS(SAB), .N_ANTS(NA), .MCNT_WIDTH(MW),
    .RD_LATENCY(LAT), .GAP_CYCLES(GAP)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .buf_rdy_i(buf_rdy), .buf_mcnt_i(buf_mcnt),
    .buf_ack_o(buf_ack_o), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
    .xeng_sync_o(xeng_sync_o), .xeng_vld_o(xeng_vld_o), .xeng_mcnt_o(xeng_mcnt_o),
    .busy_o(busy_o), .win_count_o(win_count_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model state
  int            cyc, win_s, d;
  bit            rst_prev, chk_on;
  logic [MW-1:0] win_mcnt, exp_xmcnt;
  int            exp_wc;
  int            e_busy, e_rden, e_addr, e_ack, e_sync, e_vld;
  // Phase bookkeeping
  int            ph, rel, lit_base, ph_cnt, wait_cnt, last_sync, vld_run, ack_cnt;
  bit            dropped, hit, lit_rst, idle;

  initial begin
    rst = 1'b1; en = 1'b0; buf_rdy = 1'b0; buf_mcnt = '0;
    cyc = 0; ph = 0; win_s = -1; rst_prev = 1'b1; chk_on = 1'b0;
    win_mcnt = '0; exp_xmcnt = '0; exp_wc = 0;
    lit_base = 0; ph_cnt = 0; wait_cnt = 0; last_sync = -1; vld_run = 0; ack_cnt = 0;
    dropped = 1'b0; hit = 1'b0; lit_rst = 1'b0;

    while (ph != 6 && cyc < 6000) begin
      @(negedge clk);
      if (rst_prev) begin
        win_s = -1; exp_wc = 0; exp_xmcnt = '0; chk_on = 1'b1; vld_run = 0;
      end

      // Timeline of one window, relative to the IDLE cycle that accepted it.
      d      = (win_s >= 0) ? cyc - win_s : -1000;
      e_busy = (d >= 1 && d <= 1+WIN+GAP) ? 1 : 0;
      e_rden = (d >= 2 && d <= 1+WIN) ? 1 : 0;
      e_addr = (e_rden != 0) ? d - 2 : 0;
      e_ack  = (d == 1+WIN) ? 1 : 0;
      e_sync = (d == 1+LAT) ? 1 : 0;
      e_vld  = (d >= 2+LAT && d <= 1+WIN+LAT) ? 1 : 0;
      if (d == 1+LAT) exp_xmcnt = win_mcnt;
      if (d == 2+WIN+LAT) exp_wc++;

      if (chk_on) begin
        chk("busy", int'(busy_o), e_busy);
        chk("rd_en", int'(rd_en_o), e_rden);
        chk("rd_addr", int'(rd_addr_o), e_addr);
        chk("buf_ack", int'(buf_ack_o), e_ack);
        chk("xeng_sync", int'(xeng_sync_o), e_sync);
        chk("xeng_vld", int'(xeng_vld_o), e_vld);
        chkw("xeng_mcnt", xeng_mcnt_o, exp_xmcnt);
        chk("win_count", int'(win_count_o), exp_wc);
        // Every finished window must have exactly WIN valid samples.
        if (xeng_vld_o) vld_run++;
        else if (vld_run > 0) begin
          chk("vld_len", vld_run, WIN);
          vld_run = 0;
        end
        // When the buffer stays ready, syncs repeat every
        // SYNC(1)+RUN(16)+GAP(3)+IDLE(1) = 21 cycles.
        if (ph == 2 && xeng_sync_o) begin
          if (last_sync >= 0) chk("sync_period", cyc - last_sync, 21);
          last_sync = cyc;
        end
      end

      // Hand-computed timeline for the first window.
      if (ph == 1) begin
        rel = cyc - lit_base;
        case (rel)
          1:  chk("lit_busy", int'(busy_o), 1);
          2:  begin chk("lit_addr0", int'(rd_addr_o), 0); chk("lit_rden", int'(rd_en_o), 1); end
          3:  begin chk("lit_sync", int'(xeng_sync_o), 1); chkw("lit_mcnt", xeng_mcnt_o, 48'h1234);
                    chk("lit_vld_pre", int'(xeng_vld_o), 0); end
          4:  chk("lit_vld_first", int'(xeng_vld_o), 1);
          17: begin chk("lit_addr15", int'(rd_addr_o), 15); chk("lit_ack", int'(buf_ack_o), 1); end
          18: begin chk("lit_ack_off", int'(buf_ack_o), 0); chk("lit_rden_off", int'(rd_en_o), 0); end
          19: begin chk("lit_vld_last", int'(xeng_vld_o), 1); chk("lit_wc0", int'(win_count_o), 0);
                    chkw("lit_mcnt_hold", xeng_mcnt_o, 48'h1234); end
          20: begin chk("lit_vld_off", int'(xeng_vld_o), 0); chk("lit_wc1", int'(win_count_o), 1); end
          25: begin chk("lit_idle", int'(busy_o), 0); chk("lit_no_rd", int'(rd_en_o), 0); end
          default: ;
        endcase
      end
      if (lit_rst) begin
        chk("rst_rden", int'(rd_en_o), 0);
        chk("rst_addr", int'(rd_addr_o), 0);
        chk("rst_ack", int'(buf_ack_o), 0);
        chk("rst_vld", int'(xeng_vld_o), 0);
        chk("rst_sync", int'(xeng_sync_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_wc", int'(win_count_o), 0);
        chkw("rst_mcnt", xeng_mcnt_o, '0);
        lit_rst = 1'b0;
      end

      // Stimulus for this cycle.
      case (ph)
        0: begin
          if (cyc < 3) rst = 1'b1;
          else begin
            rst = 1'b0; en = 1'b1; buf_rdy = 1'b1; buf_mcnt = 48'h1234;
            lit_base = cyc; ph = 1;
          end
        end
        1: begin
          rel = cyc - lit_base;
          en = 1'b0; buf_rdy = 1'b1;
          if (rel >= 2) buf_mcnt = {16'($urandom), $urandom};
          if (rel >= 30) begin ph = 2; ph_cnt = 0; last_sync = -1; end
        end
        2: begin
          en = 1'b1; buf_rdy = 1'b1; buf_mcnt = {16'($urandom), $urandom};
          ph_cnt++;
          if (ph_cnt >= 100) begin ph = 3; wait_cnt = 0; dropped = 1'b0; end
        end
        3: begin
          buf_rdy = 1'b1; buf_mcnt = {16'($urandom), $urandom};
          if (!dropped) begin
            en = 1'b1;
            if (rd_en_o && rd_addr_o == AW'(5)) begin
              en = 1'b0; dropped = 1'b1; ph_cnt = 0; ack_cnt = 0;
            end else begin
              wait_cnt++;
              if (wait_cnt > 60) begin
                total++; bad++;
                $display("FAIL en_drop_wait: got timeout expected rd_addr 5");
                ph = 6;
              end
            end
          end else begin
            en = 1'b0;
            if (buf_ack_o) ack_cnt++;
            ph_cnt++;
            if (ph_cnt == 40) begin
              chk("drop_ack_once", ack_cnt, 1);
              chk("drop_idle", int'(busy_o), 0);
              ph = 4; wait_cnt = 0; hit = 1'b0;
            end
          end
        end
        4: begin
          buf_rdy = 1'b1; buf_mcnt = {16'($urandom), $urandom};
          if (!hit) begin
            en = 1'b1;
            if (rd_en_o && rd_addr_o == AW'(8)) begin
              rst = 1'b1; hit = 1'b1; lit_rst = 1'b1; ph_cnt = 0;
            end else begin
              wait_cnt++;
              if (wait_cnt > 60) begin
                total++; bad++;
                $display("FAIL rst_wait: got timeout expected rd_addr 8");
                ph = 6;
              end
            end
          end else begin
            rst = 1'b0; en = 1'b0;
            ph_cnt++;
            if (ph_cnt >= 10) begin ph = 5; ph_cnt = 0; end
          end
        end
        5: begin
          rst      = ($urandom_range(0, 199) == 0);
          en       = ($urandom_range(0, 3) != 0);
          buf_rdy  = ($urandom_range(0, 3) != 0);
          buf_mcnt = {16'($urandom), $urandom};
          ph_cnt++;
          if (ph_cnt >= 1500) ph = 6;
        end
        default: ;
      endcase

      // Update the model with what the next rising edge will see.
      if (rst) rst_prev = 1'b1;
      else begin
        rst_prev = 1'b0;
        idle = (win_s < 0) || (cyc - win_s >= 2+WIN+GAP);
        if (idle && en && buf_rdy) win_s = cyc;
        else if (win_s >= 0 && cyc - win_s == 1) win_mcnt = buf_mcnt;
      end
      cyc++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
